sigma_bus_arbiter: RTL and testbench

//   Two-master round-robin arbiter placed in front of the sigma peripheral bus (CSR/LED/SW/log block at 0x0010_0000).

---
 rtl/sigma_bus_arbiter_if.sv | 24 ++
 rtl/sigma_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_sigma_bus_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sigma_bus_arbiter_if.sv
// rtl/sigma_bus_arbiter_if.sv - request/response bus bundle shared by sigma masters and the sigma slave port
interface sigma_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   wdata;
  logic                ack;
  logic                resp;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/sigma_bus_arbiter.sv
// rtl/sigma_bus_arbiter.sv - two-master round-robin arbiter for the sigma peripheral bus
// Serialises m0 (CPU) and m1 (UDM) onto one slave port with a single outstanding read and a response timeout.
module sigma_bus_arbiter #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                TIMEOUT       = 1023,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sigma_bus_arbiter_if.slave  m0_bus,
  sigma_bus_arbiter_if.slave  m1_bus,
  sigma_bus_arbiter_if.master s_bus,
  output logic                timeout_o
);

  localparam int                TCNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                timeout_q, timeout_d;

  logic                own_req;
  logic                own_we;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W/8-1:0] own_be;
  logic [DATA_W-1:0]   own_wdata;

  logic                s_req;
  logic                ack;
  logic                resp;
  logic [DATA_W-1:0]   rdata;

  always_comb begin
    if (owner_q) begin
      own_req   = m1_bus.req;
      own_we    = m1_bus.we;
      own_addr  = m1_bus.addr;
      own_be    = m1_bus.be;
      own_wdata = m1_bus.wdata;
    end else begin
      own_req   = m0_bus.req;
      own_we    = m0_bus.we;
      own_addr  = m0_bus.addr;
      own_be    = m0_bus.be;
      own_wdata = m0_bus.wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    s_req     = 1'b0;
    ack       = 1'b0;
    resp      = 1'b0;
    rdata     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_bus.req || m1_bus.req) begin
          owner_d = (m0_bus.req && m1_bus.req) ? ~last_q : m1_bus.req;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        s_req = own_req;
        // An owner that withdraws before the slave accepts forfeits its turn without moving the priority
        if (!own_req) begin
          state_d = ST_IDLE;
        end else if (s_bus.ack) begin
          ack    = 1'b1;
          last_d = owner_q;
          if (own_we) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
            tcnt_d  = '0;
          end
        end
      end
      ST_RESP: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (s_bus.resp) begin
          resp    = 1'b1;
          rdata   = s_bus.rdata;
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN && (tcnt_q == TCNT_LAST)) begin
          resp      = 1'b1;
          rdata     = TIMEOUT_RDATA;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A transaction in flight when reset arrives is dropped silently
    if (rst_i) begin
      s_req = 1'b0;
      ack   = 1'b0;
      resp  = 1'b0;
      rdata = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_bus.req    = s_req;
  assign s_bus.we     = own_we;
  assign s_bus.addr   = own_addr;
  assign s_bus.be     = own_be;
  assign s_bus.wdata  = own_wdata;

  assign m0_bus.ack   = ack & ~owner_q;
  assign m1_bus.ack   = ack & owner_q;
  assign m0_bus.resp  = resp & ~owner_q;
  assign m1_bus.resp  = resp & owner_q;
  assign m0_bus.rdata = (resp && !owner_q) ? rdata : '0;
  assign m1_bus.rdata = (resp && owner_q) ? rdata : '0;

  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sigma_bus_arbiter.sv
// tb/tb_sigma_bus_arbiter.sv - directed-vector bench for sigma_bus_arbiter
module tb_sigma_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic timeout;

  always #5 clk = ~clk;

  sigma_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  sigma_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  sigma_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  sigma_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .TIMEOUT_RDATA(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_bus(m0_bus), .m1_bus(m1_bus), .s_bus(s_bus),
    .timeout_o(timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic mreq(input int m, input logic req, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.be = 4'hf; m0_bus.wdata = wdata;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.be = 4'hf; m1_bus.wdata = wdata;
    end
  endtask

  task automatic idle_inputs();
    mreq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    mreq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack = 1'b0; s_bus.resp = 1'b0; s_bus.rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc(); smp();
    check_vec("rst_outputs", {27'h0, m0_bus.ack, m1_bus.ack, m0_bus.resp, m1_bus.resp, s_bus.req}, 32'h0);
    cyc(); rst = 1'b0; smp();
    check_vec("post_rst_outputs", {26'h0, m0_bus.ack, m1_bus.ack, m0_bus.resp, m1_bus.resp, s_bus.req, timeout}, 32'h0);
    check_vec("post_rst_state", 32'(dut.state_q), 32'd0);
  endtask

  // Issue a read from master m and leave the bench at the first RESP cycle, inputs idle
  task automatic start_read(input int m, input logic [31:0] addr, input string tag);
    cyc(); mreq(m, 1'b1, 1'b0, addr, 32'h0); smp();
    cyc(); s_bus.ack = 1'b1; smp();
    check_vec({tag, "_ack"}, {30'h0, m1_bus.ack, m0_bus.ack}, (m == 0) ? 32'd1 : 32'd2);
    cyc(); mreq(m, 1'b0, 1'b0, 32'h0, 32'h0); s_bus.ack = 1'b0;
  endtask

  task automatic wait_no_resp(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k > 0) cyc();
      smp();
      check_vec(tag, {29'h0, m1_bus.resp, m0_bus.resp, s_bus.req}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp0;
    logic [7:0] exp1;
    exp0 = 8'b0010_0010;
    exp1 = 8'b1000_1000;

    // 1: single m0 write
    do_reset();
    cyc(); mreq(0, 1'b1, 1'b1, 32'h8000_0000, 32'hdeadbeef); smp();
    check_vec("t1_idle_sreq", {31'h0, s_bus.req}, 32'h0);
    cyc(); s_bus.ack = 1'b1; smp();
    check_vec("t1_wdata", s_bus.wdata, 32'hdeadbeef);
    check_vec("t1_addr", s_bus.addr, 32'h8000_0000);
    check_vec("t1_acks", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd1);
    cyc(); idle_inputs(); smp();
    check_vec("t1_state", 32'(dut.state_q), 32'd0);
    check_vec("t1_acks_after", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd0);

    // 2: both masters writing continuously alternate m0, m1, m0, m1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) begin
        mreq(0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111);
        mreq(1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_2222);
        s_bus.ack = 1'b1;
      end
      smp();
      check_vec($sformatf("t2_acks_%0d", i), {30'h0, m1_bus.ack, m0_bus.ack}, {30'h0, exp1[i], exp0[i]});
      if (i == 3) check_vec("t2_m1_wdata", s_bus.wdata, 32'h2222_2222);
    end
    cyc(); idle_inputs(); smp();
    check_vec("t2_state", 32'(dut.state_q), 32'd0);

    // 3: m1 read with 5-cycle slave latency while m0 waits
    do_reset();
    cyc(); mreq(1, 1'b1, 1'b0, 32'h0010_0050, 32'h0); smp();
    cyc(); mreq(0, 1'b1, 1'b1, 32'h0000_0040, 32'h5a5a_5a5a); s_bus.ack = 1'b1; smp();
    check_vec("t3_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd2);
    check_vec("t3_addr", s_bus.addr, 32'h0010_0050);
    check_vec("t3_we", {31'h0, s_bus.we}, 32'h0);
    cyc(); mreq(1, 1'b0, 1'b0, 32'h0, 32'h0); s_bus.ack = 1'b0;
    wait_no_resp(4, "t3_wait");
    cyc(); s_bus.resp = 1'b1; s_bus.rdata = 32'h0011_1111; smp();
    check_vec("t3_resp", {30'h0, m1_bus.resp, m0_bus.resp}, 32'd2);
    check_vec("t3_m1_rdata", m1_bus.rdata, 32'h0011_1111);
    check_vec("t3_m0_rdata", m0_bus.rdata, 32'h0);
    cyc(); s_bus.resp = 1'b0; s_bus.rdata = 32'h0; smp();
    check_vec("t3_idle_sreq", {31'h0, s_bus.req}, 32'h0);
    cyc(); s_bus.ack = 1'b1; smp();
    check_vec("t3_m0_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd1);
    check_vec("t3_m0_wdata", s_bus.wdata, 32'h5a5a_5a5a);
    cyc(); idle_inputs();

    // 4a: slave response on the final timeout cycle wins
    do_reset();
    start_read(0, 32'h0010_0010, "t4a");
    wait_no_resp(7, "t4a_wait");
    cyc(); s_bus.resp = 1'b1; s_bus.rdata = 32'h1234_5678; smp();
    check_vec("t4a_resp", {30'h0, m1_bus.resp, m0_bus.resp}, 32'd1);
    check_vec("t4a_rdata", m0_bus.rdata, 32'h1234_5678);
    cyc(); s_bus.resp = 1'b0; s_bus.rdata = 32'h0; smp();
    check_vec("t4a_no_flag", {31'h0, timeout}, 32'h0);

    // 4b: slave never responds, timeout fires 8 cycles after ack
    start_read(0, 32'h0010_0020, "t4b");
    wait_no_resp(7, "t4b_wait");
    cyc(); smp();
    check_vec("t4b_resp", {30'h0, m1_bus.resp, m0_bus.resp}, 32'd1);
    check_vec("t4b_rdata", m0_bus.rdata, 32'hdeadbeef);
    cyc(); smp();
    check_vec("t4b_flag", {31'h0, timeout}, 32'h1);
    check_vec("t4b_resp_gone", {31'h0, m0_bus.resp}, 32'h0);
    cyc(); cyc(); cyc(); smp();
    check_vec("t4b_flag_sticky", {31'h0, timeout}, 32'h1);

    // 5: reset during RESP abandons the read
    do_reset();
    start_read(0, 32'h0010_0030, "t5");
    smp();
    cyc(); rst = 1'b1; s_bus.resp = 1'b1; s_bus.rdata = 32'hcafe_f00d; smp();
    check_vec("t5_in_rst", {30'h0, m1_bus.resp, m0_bus.resp}, 32'h0);
    cyc(); rst = 1'b0; smp();
    check_vec("t5_after_rst", {30'h0, m1_bus.resp, m0_bus.resp}, 32'h0);
    check_vec("t5_state", 32'(dut.state_q), 32'd0);
    cyc(); smp();
    check_vec("t5_late_resp", {30'h0, m1_bus.resp, m0_bus.resp}, 32'h0);
    cyc(); s_bus.resp = 1'b0; s_bus.rdata = 32'h0; mreq(0, 1'b1, 1'b1, 32'h0010_0034, 32'h0000_0077); smp();
    cyc(); s_bus.ack = 1'b1; smp();
    check_vec("t5_next_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd1);
    cyc(); idle_inputs();

    // 6: m1 withdraws in GRANT, pending m0 goes next
    do_reset();
    cyc(); mreq(1, 1'b1, 1'b0, 32'h0010_0060, 32'h0); smp();
    cyc(); mreq(1, 1'b0, 1'b0, 32'h0, 32'h0); mreq(0, 1'b1, 1'b1, 32'h0010_0070, 32'h0000_beef); smp();
    check_vec("t6_no_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd0);
    check_vec("t6_no_sreq", {31'h0, s_bus.req}, 32'h0);
    cyc(); smp();
    check_vec("t6_state", 32'(dut.state_q), 32'd0);
    cyc(); s_bus.ack = 1'b1; smp();
    check_vec("t6_m0_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'd1);
    check_vec("t6_wdata", s_bus.wdata, 32'h0000_beef);
    cyc(); idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
